// File: rtl/aplic_pkg.sv
// Shared APLIC types: source modes and gateway limits.
// Includes the per-mode rectify function used by every source channel.
package aplic_pkg;

  localparam int unsigned AplicMaxSyncLevels = 4;

  typedef enum logic [2:0] {
    SM_INACTIVE = 3'd0,
    SM_DETACHED = 3'd1,
    SM_EDGE1    = 3'd4,
    SM_EDGE0    = 3'd5,
    SM_LEVEL1   = 3'd6,
    SM_LEVEL0   = 3'd7
  } src_mode_e;

  // Reserved encodings 2 and 3 fall into the default arm and read 0.
  function automatic logic rectify(
    input logic [2:0] mode,
    input logic       lvl
  );
    logic r;
    case (mode)
      SM_EDGE1,
      SM_LEVEL1: r = lvl;
      SM_EDGE0,
      SM_LEVEL0: r = ~lvl;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aplic_src_chan.sv
// One interrupt source: synchronizer, glitch filter, rectifier
// and the registered level / pending-set pulse outputs.
module aplic_src_chan
  import aplic_pkg::*;
#(
  parameter int unsigned NrSyncLevels = 2,
  parameter int unsigned FilterW      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_src,
  input  logic [2:0]         i_mode,
  input  logic [FilterW-1:0] i_filter_len,
  output logic               o_rectified,
  output logic               o_set_pend
);

  logic [NrSyncLevels-1:0] sync_q, sync_d;
  logic [FilterW-1:0]      cnt_q, cnt_d;
  logic                    f_q, f_d;
  logic [2:0]              mode_q;
  logic                    rect_q, pend_q;
  logic                    s, r, mode_chg, pend_d;

  assign s = sync_q[NrSyncLevels-1];

  always_comb begin
    sync_d = {sync_q[NrSyncLevels-2:0], i_src};
    f_d    = f_q;
    cnt_d  = cnt_q;
    if (s == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == i_filter_len) begin
      f_d   = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // rect_q doubles as r_prev: it always holds last cycle's r.
  always_comb begin
    r        = rectify(i_mode, f_q);
    mode_chg = (i_mode != mode_q);
    pend_d   = r & ~rect_q & ~mode_chg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
      mode_q <= 3'd0;
      rect_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      mode_q <= i_mode;
      rect_q <= r;
      pend_q <= pend_d;
    end
  end

  assign o_rectified = rect_q;
  assign o_set_pend  = pend_q;

endmodule

// File: rtl/aplic_src_gateway.sv
// APLIC interrupt-source front end: one independent channel
// per source line feeding the domain pending/enable logic.
module aplic_src_gateway
  import aplic_pkg::*;
#(
  parameter int unsigned NrSources    = 32,
  parameter int unsigned NrSyncLevels = 2,
  parameter int unsigned FilterW      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NrSources-1:0]   i_irq_sources,
  input  logic [3*NrSources-1:0] i_src_mode,
  input  logic [FilterW-1:0]     i_filter_len,
  output logic [NrSources-1:0]   o_rectified,
  output logic [NrSources-1:0]   o_set_pend
);

  for (genvar i = 0; i < NrSources; i++) begin : g_chan
    aplic_src_chan #(
      .NrSyncLevels (NrSyncLevels),
      .FilterW      (FilterW)
    ) u_chan (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_src        (i_irq_sources[i]),
      .i_mode       (i_src_mode[3*i +: 3]),
      .i_filter_len (i_filter_len),
      .o_rectified  (o_rectified[i]),
      .o_set_pend   (o_set_pend[i])
    );
  end

endmodule
